// File: rtl/clk_div_gen_if.sv
// Control/status bundle for clk_div_gen: per-channel run enables and divisor loads in,
// divided clocks and status strobes out.
interface clk_div_gen_if #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 8
);
  logic [NUM_CH-1:0]       ch_en;
  logic [NUM_CH*CNT_W-1:0] div_in;
  logic [NUM_CH-1:0]       div_ld;
  logic [NUM_CH-1:0]       clk_out;
  logic [NUM_CH-1:0]       ce_rise;
  logic [NUM_CH-1:0]       div_ack;
  logic [NUM_CH-1:0]       div_err;
  logic [NUM_CH-1:0]       running;

  modport master (
    output ch_en, div_in, div_ld,
    input  clk_out, ce_rise, div_ack, div_err, running
  );

  modport slave (
    input  ch_en, div_in, div_ld,
    output clk_out, ce_rise, div_ack, div_err, running
  );
endinterface

// File: rtl/clk_div_gen.sv
// Multi-channel clk_50m divider with glitch-free start/stop and period-boundary divisor reload.
// Optional macro CLK_DIV_ODD_DUTY50_EN adds a negedge flop per channel for exact 50% duty on odd divisors.
module clk_div_gen #(
  parameter int                      NUM_CH   = 2,
  parameter int                      CNT_W    = 8,
  parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT = {8'd5, 8'd26}
) (
  input  logic         clk_50m,
  input  logic         rst_n,
  clk_div_gen_if.slave cdg_if
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    localparam logic [CNT_W-1:0] INIT_DIV = DIV_INIT[g*CNT_W +: CNT_W];

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cur_div_q, cur_div_d;
    logic [CNT_W-1:0] pend_div_q, pend_div_d;
    logic             pend_vld_q, pend_vld_d;
    logic             clk_q, clk_d;
    logic             ce_q, ce_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;
    logic             run_q, run_d;

    logic [CNT_W-1:0] div_in_s;
    logic [CNT_W-1:0] eff_div_s;
    logic [CNT_W-1:0] cnt_inc_s;
    logic             ld_ok_s;
    logic             eff_vld_s;
    logic             wrap_s;
    logic             apply_s;

    assign div_in_s  = cdg_if.div_in[g*CNT_W +: CNT_W];
    assign ld_ok_s   = cdg_if.div_ld[g] && (div_in_s >= CNT_W'(2));
    // A load arriving on the apply cycle wins over the registered pending value.
    assign eff_vld_s = ld_ok_s | pend_vld_q;
    assign eff_div_s = ld_ok_s ? div_in_s : pend_div_q;
    assign wrap_s    = (cnt_q == (cur_div_q - CNT_W'(1)));
    assign cnt_inc_s = cnt_q + CNT_W'(1);
    assign apply_s   = eff_vld_s && ((state_q == ST_IDLE) || wrap_s);

    // Next-state: divisor bookkeeping, then run/stop sequencing.
    always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      cur_div_d  = cur_div_q;
      pend_div_d = pend_div_q;
      pend_vld_d = pend_vld_q;
      clk_d      = clk_q;
      ce_d       = 1'b0;
      ack_d      = 1'b0;
      err_d      = cdg_if.div_ld[g] & ~ld_ok_s;
      run_d      = run_q;

      if (apply_s) begin
        cur_div_d  = eff_div_s;
        pend_vld_d = 1'b0;
        ack_d      = 1'b1;
      end else if (ld_ok_s) begin
        pend_div_d = div_in_s;
        pend_vld_d = 1'b1;
      end else begin
        ack_d      = 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (cdg_if.ch_en[g]) begin
            state_d = ST_RUN;
            cnt_d   = {CNT_W{1'b0}};
            clk_d   = 1'b1;
            ce_d    = 1'b1;
            run_d   = 1'b1;
          end else begin
            cnt_d   = {CNT_W{1'b0}};
            clk_d   = 1'b0;
            run_d   = 1'b0;
          end
        end
        ST_RUN: begin
          if (!wrap_s) begin
            cnt_d = cnt_inc_s;
            clk_d = (cnt_inc_s < (cur_div_q >> 1));
          end else if (cdg_if.ch_en[g]) begin
            // Every legal divisor has H >= 1, so a fresh period always opens high.
            cnt_d = {CNT_W{1'b0}};
            clk_d = 1'b1;
            ce_d  = 1'b1;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = {CNT_W{1'b0}};
            clk_d   = 1'b0;
            run_d   = 1'b0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = {CNT_W{1'b0}};
          clk_d   = 1'b0;
          run_d   = 1'b0;
        end
      endcase
    end

    // Channel state and output registers.
    always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
        state_q    <= ST_IDLE;
        cnt_q      <= {CNT_W{1'b0}};
        cur_div_q  <= INIT_DIV;
        pend_div_q <= {CNT_W{1'b0}};
        pend_vld_q <= 1'b0;
        clk_q      <= 1'b0;
        ce_q       <= 1'b0;
        ack_q      <= 1'b0;
        err_q      <= 1'b0;
        run_q      <= 1'b0;
      end else begin
        state_q    <= state_d;
        cnt_q      <= cnt_d;
        cur_div_q  <= cur_div_d;
        pend_div_q <= pend_div_d;
        pend_vld_q <= pend_vld_d;
        clk_q      <= clk_d;
        ce_q       <= ce_d;
        ack_q      <= ack_d;
        err_q      <= err_d;
        run_q      <= run_d;
      end
    end

`ifdef CLK_DIV_ODD_DUTY50_EN
    logic neg_q;

    // Half-cycle delayed copy stretches the high phase by half a source cycle.
    always_ff @(negedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
        neg_q <= 1'b0;
      end else begin
        neg_q <= clk_q;
      end
    end

    assign cdg_if.clk_out[g] = clk_q | (neg_q & cur_div_q[0]);
`else
    assign cdg_if.clk_out[g] = clk_q;
`endif

    assign cdg_if.ce_rise[g] = ce_q;
    assign cdg_if.div_ack[g] = ack_q;
    assign cdg_if.div_err[g] = err_q;
    assign cdg_if.running[g] = run_q;
  end

endmodule

// File: tb/tb_clk_div_gen.sv
// Directed self-checking bench for clk_div_gen (2 channels, /26 and /5 at reset).
module tb_clk_div_gen;

  logic clk_50m = 1'b0;
  logic rst_n   = 1'b0;
  int   checks  = 0;
  int   errors  = 0;

  int m_hi[2], m_ce[2], m_gmin[2], m_gmax[2], m_ack[2], m_run[2], m_bad[2];

  clk_div_gen_if #(.NUM_CH(2), .CNT_W(8)) cdg_if ();

  clk_div_gen #(
    .NUM_CH  (2),
    .CNT_W   (8),
    .DIV_INIT({8'd5, 8'd26})
  ) u_dut (
    .clk_50m(clk_50m),
    .rst_n  (rst_n),
    .cdg_if (cdg_if)
  );

  always #10 clk_50m = ~clk_50m;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_50m);
    #1;
  endtask

  task automatic wait_ce(input int ch, output int k);
    k = 0;
    do begin
      step();
      k++;
    end while (!cdg_if.ce_rise[ch] && k < 300);
  endtask

  // Samples every channel for n cycles, counting high cycles, strobes and ce_rise spacing.
  task automatic measure(input int n);
    int last_ce[2];
    logic prev_clk[2];
    for (int c = 0; c < 2; c++) begin
      m_hi[c] = 0; m_ce[c] = 0; m_gmin[c] = 9999; m_gmax[c] = 0;
      m_ack[c] = 0; m_run[c] = 0; m_bad[c] = 0; last_ce[c] = -1;
      prev_clk[c] = cdg_if.clk_out[c];
    end
    for (int i = 0; i < n; i++) begin
      step();
      for (int c = 0; c < 2; c++) begin
        if (cdg_if.clk_out[c]) m_hi[c]++;
        if (cdg_if.div_ack[c]) m_ack[c]++;
        if (cdg_if.running[c]) m_run[c]++;
        if (cdg_if.ce_rise[c]) begin
          m_ce[c]++;
          if (!(cdg_if.clk_out[c] && !prev_clk[c])) m_bad[c]++;
          if (last_ce[c] >= 0) begin
            if (i - last_ce[c] < m_gmin[c]) m_gmin[c] = i - last_ce[c];
            if (i - last_ce[c] > m_gmax[c]) m_gmax[c] = i - last_ce[c];
          end
          last_ce[c] = i;
        end
        prev_clk[c] = cdg_if.clk_out[c];
      end
    end
  endtask

  initial begin
    int k;
    int hi;
    int t_rise;
    int t_fall;
    cdg_if.ch_en  = 2'b00;
    cdg_if.div_in = 16'd0;
    cdg_if.div_ld = 2'b00;

    // Reset state
    step(); step();
    check_val("rst_clk_out", cdg_if.clk_out, 2'b00);
    check_val("rst_ce_rise", cdg_if.ce_rise, 2'b00);
    check_val("rst_div_ack", cdg_if.div_ack, 2'b00);
    check_val("rst_div_err", cdg_if.div_err, 2'b00);
    check_val("rst_running", cdg_if.running, 2'b00);
    rst_n = 1'b1;
    step(); step();
    check_val("idle_running", cdg_if.running, 2'b00);

    // Default divisors: ch0 /26, ch1 /5 over one common window of 130 cycles
    cdg_if.ch_en = 2'b11;
    measure(130);
    check_val("t1_ch0_hi", m_hi[0], 65);
    check_val("t1_ch0_ce", m_ce[0], 5);
    check_val("t1_ch0_gmin", m_gmin[0], 26);
    check_val("t1_ch0_gmax", m_gmax[0], 26);
    check_val("t1_ch0_align", m_bad[0], 0);
`ifdef CLK_DIV_ODD_DUTY50_EN
    check_val("t1_ch1_hi", m_hi[1], 78);
`else
    check_val("t1_ch1_hi", m_hi[1], 52);
`endif
    check_val("t1_ch1_ce", m_ce[1], 26);
    check_val("t1_ch1_gmin", m_gmin[1], 5);
    check_val("t1_ch1_gmax", m_gmax[1], 5);
    check_val("t1_ch1_align", m_bad[1], 0);
    check_val("t1_run", m_run[0] + m_run[1], 260);

    // Load /10 at cnt=5: the /26 period completes, ack lands on the wrap
    wait_ce(0, k);
    repeat (5) step();
    cdg_if.div_in = {8'd0, 8'd10};
    cdg_if.div_ld = 2'b01;
    step();
    cdg_if.div_ld = 2'b00;
    check_val("t2_ack_early", cdg_if.div_ack[0], 1'b0);
    wait_ce(0, k);
    check_val("t2_wrap_dist", k, 20);
    check_val("t2_ack_wrap", cdg_if.div_ack[0], 1'b1);
    measure(30);
    check_val("t2_hi", m_hi[0], 15);
    check_val("t2_ce", m_ce[0], 3);
    check_val("t2_gmin", m_gmin[0], 10);
    check_val("t2_gmax", m_gmax[0], 10);
    check_val("t2_ack_after", m_ack[0], 0);

    // Enable dropped at cnt=3, restored at cnt=8: no stop
    repeat (3) step();
    cdg_if.ch_en[0] = 1'b0;
    repeat (5) step();
    cdg_if.ch_en[0] = 1'b1;
    measure(20);
    check_val("t3_run", m_run[0], 20);
    check_val("t3_ce", m_ce[0], 2);
    check_val("t3_hi", m_hi[0], 10);

    // Enable dropped at cnt=3 and held: period completes, then idle
    repeat (2) step();
    repeat (3) step();
    cdg_if.ch_en[0] = 1'b0;
    k = 0;
    hi = 0;
    do begin
      step();
      k++;
      if (cdg_if.clk_out[0]) hi++;
    end while (cdg_if.running[0] && k < 40);
    check_val("t4_stop_dist", k, 7);
    check_val("t4_tail_hi", hi, 1);
    check_val("t4_clk_low", cdg_if.clk_out[0], 1'b0);
    measure(20);
    check_val("t4_idle_hi", m_hi[0], 0);
    check_val("t4_idle_ce", m_ce[0], 0);
    check_val("t4_idle_run", m_run[0], 0);

    // Illegal divisors 1 and 0 are rejected
    cdg_if.div_in = {8'd0, 8'd1};
    cdg_if.div_ld = 2'b01;
    step();
    check_val("t5_err1", cdg_if.div_err[0], 1'b1);
    check_val("t5_ack1", cdg_if.div_ack[0], 1'b0);
    cdg_if.div_in = {8'd0, 8'd0};
    step();
    cdg_if.div_ld = 2'b00;
    check_val("t5_err0", cdg_if.div_err[0], 1'b1);
    check_val("t5_ack0", cdg_if.div_ack[0], 1'b0);
    step();
    check_val("t5_err_clear", cdg_if.div_err[0], 1'b0);

    // Restart: divisor still 10
    cdg_if.ch_en[0] = 1'b1;
    step();
    check_val("t6_start_run", cdg_if.running[0], 1'b1);
    check_val("t6_start_clk", cdg_if.clk_out[0], 1'b1);
    check_val("t6_start_ce", cdg_if.ce_rise[0], 1'b1);
    check_val("t6_start_ack", cdg_if.div_ack[0], 1'b0);
    measure(20);
    check_val("t6_hi", m_hi[0], 10);
    check_val("t6_gap", m_gmax[0], 10);

    // Two loads (12 then 8) before wrap: last wins, one ack
    repeat (2) step();
    cdg_if.div_in = {8'd0, 8'd12};
    cdg_if.div_ld = 2'b01;
    step();
    cdg_if.div_in = {8'd0, 8'd8};
    step();
    cdg_if.div_ld = 2'b00;
    check_val("t7_ack_early", cdg_if.div_ack[0], 1'b0);
    wait_ce(0, k);
    check_val("t7_wrap_dist", k, 6);
    check_val("t7_ack_wrap", cdg_if.div_ack[0], 1'b1);
    measure(24);
    check_val("t7_hi", m_hi[0], 12);
    check_val("t7_ce", m_ce[0], 3);
    check_val("t7_gap", m_gmin[0], 8);
    check_val("t7_single_ack", m_ack[0], 0);

    // Load on the wrap cycle bypasses straight into the next period
    repeat (7) step();
    cdg_if.div_in = {8'd0, 8'd6};
    cdg_if.div_ld = 2'b01;
    step();
    cdg_if.div_ld = 2'b00;
    check_val("t8_ce", cdg_if.ce_rise[0], 1'b1);
    check_val("t8_ack", cdg_if.div_ack[0], 1'b1);
    measure(12);
    check_val("t8_hi", m_hi[0], 6);
    check_val("t8_gap", m_gmax[0], 6);

    // Asynchronous reset during the high phase
    check_val("t9_pre_clk", cdg_if.clk_out[0], 1'b1);
    rst_n = 1'b0;
    #2;
    check_val("t9_rst_clk", cdg_if.clk_out, 2'b00);
    check_val("t9_rst_run", cdg_if.running, 2'b00);
    step();
    rst_n = 1'b1;

`ifdef CLK_DIV_ODD_DUTY50_EN
    // Odd divisor with duty fix: /5 high for 2.5 source cycles
    k = 0;
    while (cdg_if.clk_out[1] !== 1'b1 && k < 400) begin #1; k++; end
    t_rise = $time;
    k = 0;
    while (cdg_if.clk_out[1] !== 1'b0 && k < 400) begin #1; k++; end
    t_fall = $time;
    check_val("t10_high_time", t_fall - t_rise, 50);
`else
    t_rise = 0;
    t_fall = 0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
